// File: rtl/showing_ls_byte_pkg.sv
// Shared types and constants for the LS-byte decimal display driver.
package showing_ls_byte_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0-9.
  localparam seg7_t SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam int BYTE_LSB = 0;
  localparam int BYTE_W   = 8;

  // Any code above 9 decodes to blank; this one is used for leading-zero suppression.
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

endpackage

// File: rtl/showing_ls_byte_if.sv
// Result-word input and three 7-segment outputs of the display driver.
interface showing_ls_byte_if
  import showing_ls_byte_pkg::*;
#(
  parameter int DATA_W = 128
);

  logic [DATA_W-1:0] data_in;
  seg7_t             Seg1;
  seg7_t             Seg2;
  seg7_t             Seg3;

  modport master (output data_in, input Seg1, Seg2, Seg3);
  modport slave  (input data_in, output Seg1, Seg2, Seg3);

endinterface

// File: rtl/showing_ls_byte_seg7_decode.sv
// Digit (0-9) to active-low 7-segment pattern, combinational; codes 10-15 show blank.
// No state, no backpressure.
module seg7_decode
  import showing_ls_byte_pkg::*;
(
  input  logic [3:0] digit,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (digit == 4'(i)) seg = SEG_DIGIT[i];
    end
  end

endmodule

// File: rtl/showing_ls_byte.sv
// Shows data_in[7:0] as three decimal 7-seg digits; 2-clock latency, one byte per clock, no backpressure.
// Optional leading-zero blanking: SHOWING_LS_BYTE_ZERO_BLANK_EN.
module showing_ls_byte
  import showing_ls_byte_pkg::*;
#(
  parameter int DATA_W = 128
)
(
  input  logic             clk,
  input  logic             reset,
  showing_ls_byte_if.slave bus
);

  logic [DATA_W-1:0] word_unused;
  logic [BYTE_W-1:0] byte_q;
  logic              cap_vld;
  logic [1:0]        hund;
  logic [6:0]        rem;
  logic [3:0]        tens;
  logic [3:0]        units;
  logic [3:0]        d1;
  logic [3:0]        d2;
  logic [3:0]        d3;
  seg7_t             seg1_d;
  seg7_t             seg2_d;
  seg7_t             seg3_d;
  seg7_t             seg1_q;
  seg7_t             seg2_q;
  seg7_t             seg3_q;

  assign word_unused = bus.data_in;

  // cap_vld keeps the outputs blank until a post-reset byte has actually been captured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_q  <= '0;
      cap_vld <= 1'b0;
    end else begin
      byte_q  <= bus.data_in[BYTE_LSB +: BYTE_W];
      cap_vld <= 1'b1;
    end
  end

  always_comb begin
    hund = 2'd0;
    rem  = byte_q[6:0];
    if (byte_q >= 8'd200) begin
      hund = 2'd2;
      rem  = 7'(byte_q - 8'd200);
    end else if (byte_q >= 8'd100) begin
      hund = 2'd1;
      rem  = 7'(byte_q - 8'd100);
    end
    tens  = 4'(rem / 7'd10);
    units = 4'(rem % 7'd10);
  end

  always_comb begin
    d1 = {2'b00, hund};
    d2 = tens;
    d3 = units;
`ifdef SHOWING_LS_BYTE_ZERO_BLANK_EN
    if (byte_q < 8'd100) d1 = DIGIT_BLANK;
    if (byte_q < 8'd10)  d2 = DIGIT_BLANK;
`endif
  end

  seg7_decode u_dec_hund  (.digit(d1), .seg(seg1_d));
  seg7_decode u_dec_tens  (.digit(d2), .seg(seg2_d));
  seg7_decode u_dec_units (.digit(d3), .seg(seg3_d));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg1_q <= SEG_BLANK;
      seg2_q <= SEG_BLANK;
      seg3_q <= SEG_BLANK;
    end else if (cap_vld) begin
      seg1_q <= seg1_d;
      seg2_q <= seg2_d;
      seg3_q <= seg3_d;
    end
  end

  assign bus.Seg1 = seg1_q;
  assign bus.Seg2 = seg2_q;
  assign bus.Seg3 = seg3_q;

endmodule

// File: tb/tb_showing_ls_byte.sv
// Directed bench for showing_ls_byte; expected segment patterns are hand-computed.
module tb_showing_ls_byte;

`ifdef SHOWING_LS_BYTE_ZERO_BLANK_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [20:0] got;
  logic [20:0] exp;

  showing_ls_byte_if #(.DATA_W(128)) bus ();

  showing_ls_byte #(.DATA_W(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic set_word(input logic [127:0] w);
    @(negedge clk);
    bus.data_in = w;
  endtask

  task automatic test_reset;
    bus.data_in = 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978;
    #1 reset = 1'b0;
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    exp = {7'h7F, 7'h7F, 7'h7F};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_async got %h expected %h", got, exp);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.data_in = {128{1'b1}};
    repeat (2) @(posedge clk);
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    exp = {7'h24, 7'h12, 7'h12};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_release_255 got %h expected %h", got, exp);
    end
  endtask

  task automatic test_upper_bits;
    set_word(128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff);
    repeat (2) @(posedge clk);
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    exp = {7'h24, 7'h12, 7'h12};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL upper_pattern got %h expected %h", got, exp);
    end
    set_word(128'h0000_0000_0000_0000_0000_0000_0000_00ff);
    repeat (2) @(posedge clk);
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL upper_zero got %h expected %h", got, exp);
    end
    set_word(128'h5a5a_a5a5_ffff_0000_1234_5678_9abc_deff);
    repeat (3) @(posedge clk);
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL upper_toggle got %h expected %h", got, exp);
    end
  endtask

  task automatic test_zero_blank;
    set_word(128'h0);
    repeat (2) @(posedge clk);
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    exp = ZB ? {7'h7F, 7'h7F, 7'h40} : {7'h40, 7'h40, 7'h40};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL byte_00 got %h expected %h", got, exp);
    end
    set_word(128'h07);
    @(posedge clk);
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL latency_hold got %h expected %h", got, exp);
    end
    @(posedge clk);
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    exp = ZB ? {7'h7F, 7'h7F, 7'h78} : {7'h40, 7'h40, 7'h78};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL byte_07 got %h expected %h", got, exp);
    end
    set_word(128'h64);
    repeat (2) @(posedge clk);
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    exp = {7'h79, 7'h40, 7'h40};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL byte_100 got %h expected %h", got, exp);
    end
  endtask

  task automatic test_back_to_back;
    set_word(128'h0A);
    @(posedge clk);
    set_word(128'h63);
    @(posedge clk);
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    exp = ZB ? {7'h7F, 7'h79, 7'h40} : {7'h40, 7'h79, 7'h40};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL b2b_010 got %h expected %h", got, exp);
    end
    set_word(128'hC8);
    @(posedge clk);
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    exp = ZB ? {7'h7F, 7'h10, 7'h10} : {7'h40, 7'h10, 7'h10};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL b2b_099 got %h expected %h", got, exp);
    end
    @(posedge clk);
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    exp = {7'h24, 7'h40, 7'h40};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL b2b_200 got %h expected %h", got, exp);
    end
  endtask

  task automatic test_mid_reset;
    set_word(128'hFF);
    repeat (2) @(posedge clk);
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    exp = {7'h24, 7'h12, 7'h12};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mid_pre_255 got %h expected %h", got, exp);
    end
    #1 reset = 1'b0;
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    exp = {7'h7F, 7'h7F, 7'h7F};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mid_async_blank got %h expected %h", got, exp);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mid_first_edge got %h expected %h", got, exp);
    end
    @(posedge clk);
    #1;
    got = {bus.Seg1, bus.Seg2, bus.Seg3};
    exp = {7'h24, 7'h12, 7'h12};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mid_second_edge got %h expected %h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_upper_bits();
    test_zero_blank();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
